// File: rtl/spi_slave.sv
// SPI responder: oversampled sclk/cs_n/mosi, one-deep transmit holding register, all CPOL/CPHA modes.
// Optional `SPI_SLAVE_FRAME_ERR_EN adds frame_err_o (truncated word or transmit underrun).
module spi_slave #(
   parameter int unsigned          DATA_WIDTH = 16,
   parameter bit                   CPOL       = 1'b0,
   parameter bit                   CPHA       = 1'b0,
   parameter bit                   LSB_FIRST  = 1'b0,
   parameter logic [DATA_WIDTH-1:0] IDLE_FILL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk_i,
   input  logic                  cs_n_i,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic                  miso_oe_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   output logic                  active_o
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,
   output logic                  frame_err_o
`endif
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [0:0] {StIdle, StFrame} state_e;

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] r,
                                                      input logic b);
      return LSB_FIRST ? {b, r[DATA_WIDTH-1:1]} : {r[DATA_WIDTH-2:0], b};
   endfunction

   // Synchronizers and edge history
   logic sclk_s1_q, sclk_s2_q, sclk_h_q;
   logic cs_s1_q, cs_s2_q, cs_h_q;
   logic mosi_s1_q, mosi_s2_q;
   logic [1:0] fill_q, fill_d;
   logic armed_q, armed_d;

   state_e                state_q, state_d;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic                  miso_q, miso_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic                  frame_err_q, frame_err_d;
   logic                  underrun_q, underrun_d;
`endif

   logic                  sclk_lead, sclk_trail, sample_edge, drive_edge;
   logic                  cs_fall, cs_rise, load_word;
   logic [DATA_WIDTH-1:0] tx_word, rx_next;

   assign sclk_lead   = (sclk_s2_q != CPOL) && (sclk_h_q == CPOL);
   assign sclk_trail  = (sclk_s2_q == CPOL) && (sclk_h_q != CPOL);
   assign sample_edge = CPHA ? sclk_trail : sclk_lead;
   assign drive_edge  = CPHA ? sclk_lead : sclk_trail;
   assign cs_fall     = cs_h_q && !cs_s2_q;
   assign cs_rise     = !cs_h_q && cs_s2_q;
   assign tx_word     = hold_full_q ? hold_q : IDLE_FILL;
   assign rx_next     = shift_in(rx_sr_q, mosi_s2_q);

   always_comb begin
      fill_d      = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
      // Only arm once the synchronizer holds real pin data and cs_n has been seen high,
      // so a cs_n held low across reset never opens a frame.
      armed_d     = armed_q || (fill_q[1] && cs_s2_q);
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      miso_d      = miso_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load_word   = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_d = 1'b0;
      underrun_d  = underrun_q;
`endif

      unique case (state_q)
         StIdle: begin
            miso_d    = 1'b0;
            bit_cnt_d = '0;
            if (cs_fall && armed_q) begin
               state_d   = StFrame;
               load_word = 1'b1;
            end
         end
         StFrame: begin
            if (cs_rise) begin
               state_d   = StIdle;
               miso_d    = 1'b0;
               bit_cnt_d = '0;
               rx_sr_d   = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
               frame_err_d = (bit_cnt_q != '0);
               underrun_d  = 1'b0;
`endif
            end else begin
               // CPHA=0: the trailing edge right after a reload would skip the new first bit
               if (drive_edge && !(!CPHA && bit_cnt_q == '0)) begin
                  miso_d  = first_bit(tx_sr_q);
                  tx_sr_d = shift_out(tx_sr_q);
               end
               if (sample_edge) begin
                  rx_sr_d   = rx_next;
                  bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                  if (bit_cnt_q == '0 && underrun_q) begin
                     frame_err_d = 1'b1;
                     underrun_d  = 1'b0;
                  end
`endif
                  if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                     rx_data_d  = rx_next;
                     rx_valid_d = 1'b1;
                     bit_cnt_d  = '0;
                     load_word  = 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load_word) begin
         if (!CPHA) begin
            miso_d  = first_bit(tx_word);
            tx_sr_d = shift_out(tx_word);
         end else begin
            tx_sr_d = tx_word;
         end
         hold_full_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         // Underrun is reported when the filler word actually starts clocking out
         underrun_d = !hold_full_q;
`endif
      end

      if (tx_valid_i && !hold_full_q) begin
         hold_d      = tx_data_i;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_s1_q   <= CPOL;
         sclk_s2_q   <= CPOL;
         sclk_h_q    <= CPOL;
         cs_s1_q     <= 1'b1;
         cs_s2_q     <= 1'b1;
         cs_h_q      <= 1'b1;
         mosi_s1_q   <= 1'b0;
         mosi_s2_q   <= 1'b0;
         fill_q      <= 2'd0;
         armed_q     <= 1'b0;
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         miso_q      <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err_q <= 1'b0;
         underrun_q  <= 1'b0;
`endif
      end else begin
         sclk_s1_q   <= sclk_i;
         sclk_s2_q   <= sclk_s1_q;
         sclk_h_q    <= sclk_s2_q;
         cs_s1_q     <= cs_n_i;
         cs_s2_q     <= cs_s1_q;
         cs_h_q      <= cs_s2_q;
         mosi_s1_q   <= mosi_i;
         mosi_s2_q   <= mosi_s1_q;
         fill_q      <= fill_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         miso_q      <= miso_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err_q <= frame_err_d;
         underrun_q  <= underrun_d;
`endif
      end
   end

   assign miso_o     = miso_q;
   assign miso_oe_o  = (state_q == StFrame);
   assign active_o   = (state_q == StFrame);
   assign tx_ready_o = !hold_full_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: four instances (mode 0 MSB-first fill 0; modes 1-3 LSB-first fill FFFF)
// driven by a bit-level SPI controller model and checked against word-level expectations.
module tb_spi_slave;

   localparam int H = 16;  // sclk half period in clk cycles (sclk = clk/32)

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sclk, cs_n, mosi, miso, miso_oe, tx_valid, tx_ready, rx_valid, active;
   logic [15:0] tx_data [4];
   logic [15:0] rx_data [4];
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic [3:0]  frame_err;
   int          ferr_cnt [4] = '{default: 0};
`endif
   int          rxv_cnt [4] = '{default: 0};
   int          total = 0;
   int          bad = 0;
   logic [31:0] cap, cap2;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam bit          Cpol = (g >= 2);
      localparam bit          Cpha = (g % 2 == 1);
      localparam bit          Lsb  = (g != 0);
      localparam logic [15:0] Fill = (g == 0) ? 16'h0000 : 16'hFFFF;
      spi_slave #(
         .DATA_WIDTH(16), .CPOL(Cpol), .CPHA(Cpha), .LSB_FIRST(Lsb), .IDLE_FILL(Fill)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .sclk_i    (sclk[g]),
         .cs_n_i    (cs_n[g]),
         .mosi_i    (mosi[g]),
         .miso_o    (miso[g]),
         .miso_oe_o (miso_oe[g]),
         .tx_data_i (tx_data[g]),
         .tx_valid_i(tx_valid[g]),
         .tx_ready_o(tx_ready[g]),
         .rx_data_o (rx_data[g]),
         .rx_valid_o(rx_valid[g]),
         .active_o  (active[g])
`ifdef SPI_SLAVE_FRAME_ERR_EN
         ,
         .frame_err_o(frame_err[g])
`endif
      );
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rx_valid[i] === 1'b1) rxv_cnt[i] <= rxv_cnt[i] + 1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         if (frame_err[i] === 1'b1) ferr_cnt[i] <= ferr_cnt[i] + 1;
`endif
      end
   end

   function automatic bit cfg_cpol(input int sel); return sel >= 2; endfunction
   function automatic bit cfg_cpha(input int sel); return sel % 2 == 1; endfunction
   function automatic bit cfg_lsb(input int sel); return sel != 0; endfunction
   function automatic logic [15:0] cfg_fill(input int sel);
      return (sel == 0) ? 16'h0000 : 16'hFFFF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Controller: clocks nbits bits; word k occupies mw[16k+15:16k], same layout for captured miso.
   task automatic xfer(input int sel, input int nbits, input logic [31:0] mw,
                       input bit do_fall, input bit do_rise, output logic [31:0] c);
      bit cpol, cpha, lsb;
      cpol = cfg_cpol(sel);
      cpha = cfg_cpha(sel);
      lsb  = cfg_lsb(sel);
      c    = '0;
      if (do_fall) begin
         cs_n[sel] = 1'b0;
         wait_clk(H);
      end
      for (int i = 0; i < nbits; i++) begin
         int b;
         b = (i / 16) * 16 + (lsb ? (i % 16) : (15 - i % 16));
         if (!cpha) begin
            mosi[sel] = mw[b];
            wait_clk(H);
            sclk[sel] = ~cpol;
            c[b] = miso[sel];
            wait_clk(H);
            sclk[sel] = cpol;
         end else begin
            sclk[sel] = ~cpol;
            mosi[sel] = mw[b];
            wait_clk(H);
            sclk[sel] = cpol;
            c[b] = miso[sel];
            wait_clk(H);
         end
      end
      if (do_rise) begin
         wait_clk(H);
         cs_n[sel] = 1'b1;
         wait_clk(H);
      end
   endtask

   task automatic preload(input int sel, input logic [15:0] w);
      int n;
      n = 0;
      while (tx_ready[sel] !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("tx_ready_before_load", {31'd0, tx_ready[sel]}, 32'd1);
      tx_data[sel]  = w;
      tx_valid[sel] = 1'b1;
      @(negedge clk);
      tx_valid[sel] = 1'b0;
   endtask

   typedef struct {
      int          sel;
      bit          pre;
      logic [15:0] pre_w;
      logic [15:0] mosi_w;
      logic [15:0] exp_miso;
      logic [15:0] exp_rx;
   } vec_t;

   // Full single-word frame with word-level expectations
   task automatic run_word(input vec_t v);
      int rc;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      int fc;
      fc = ferr_cnt[v.sel];
`endif
      if (v.pre) preload(v.sel, v.pre_w);
      rc = rxv_cnt[v.sel];
      chk("miso_oe_before", {31'd0, miso_oe[v.sel]}, 32'd0);
      xfer(v.sel, 16, {16'h0, v.mosi_w}, 1'b1, 1'b1, cap);
      chk($sformatf("miso_word_i%0d", v.sel), {16'h0, cap[15:0]}, {16'h0, v.exp_miso});
      chk($sformatf("rx_data_i%0d", v.sel), {16'h0, rx_data[v.sel]}, {16'h0, v.exp_rx});
      chk("rx_valid_pulses", rxv_cnt[v.sel] - rc, 32'd1);
      chk("miso_oe_after", {31'd0, miso_oe[v.sel]}, 32'd0);
      chk("tx_ready_after", {31'd0, tx_ready[v.sel]}, 32'd1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      chk("frame_err_underrun", ferr_cnt[v.sel] - fc, v.pre ? 32'd0 : 32'd1);
`endif
   endtask

   vec_t vecs [6];
   vec_t rv;
   int   rc0;
   logic [15:0] prev_rx;

   initial begin
      vecs[0] = '{0, 1'b1, 16'hA55A, 16'h1234, 16'hA55A, 16'h1234};
      vecs[1] = '{1, 1'b1, 16'h00F1, 16'h8003, 16'h00F1, 16'h8003};
      vecs[2] = '{2, 1'b1, 16'h00F1, 16'h8003, 16'h00F1, 16'h8003};
      vecs[3] = '{3, 1'b1, 16'h00F1, 16'h8003, 16'h00F1, 16'h8003};
      vecs[4] = '{1, 1'b0, 16'h0000, 16'h5A5A, 16'hFFFF, 16'h5A5A};
      vecs[5] = '{0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 16'h0001};

      rst      = 1'b1;
      sclk     = 4'b1100;
      cs_n     = 4'hF;
      mosi     = 4'h0;
      tx_valid = 4'h0;
      for (int i = 0; i < 4; i++) tx_data[i] = 16'h0;
      wait_clk(4);
      chk("reset_tx_ready", {28'd0, tx_ready}, 32'hF);
      chk("reset_miso_oe", {28'd0, miso_oe}, 32'h0);
      chk("reset_miso", {28'd0, miso}, 32'h0);
      chk("reset_active", {28'd0, active}, 32'h0);
      chk("reset_rx_valid", {28'd0, rx_valid}, 32'h0);
      chk("reset_rx_data0", {16'h0, rx_data[0]}, 32'h0);
      rst = 1'b0;
      wait_clk(8);

      for (int i = 0; i < 6; i++) run_word(vecs[i]);

      // Randomized single-word frames; expectation is the preloaded word or the instance filler
      for (int t = 0; t < 10; t++) begin
         rv.sel    = $urandom_range(0, 3);
         rv.pre    = $urandom_range(0, 1);
         rv.pre_w  = 16'($urandom);
         rv.mosi_w = 16'($urandom);
         rv.exp_miso = rv.pre ? rv.pre_w : cfg_fill(rv.sel);
         rv.exp_rx   = rv.mosi_w;
         run_word(rv);
      end

      // Back-to-back words in one frame, second word loaded once the first is consumed
      preload(0, 16'h1111);
      rc0 = rxv_cnt[0];
      fork
         xfer(0, 32, {16'h5678, 16'h9ABC}, 1'b1, 1'b1, cap2);
         preload(0, 16'h2222);
      join
      chk("b2b_miso", cap2, {16'h2222, 16'h1111});
      chk("b2b_rx_data", {16'h0, rx_data[0]}, 32'h5678);
      chk("b2b_rx_valid_pulses", rxv_cnt[0] - rc0, 32'd2);

      // Truncated frame after 7 bits, then a clean one
      prev_rx = rx_data[0];
      rc0 = rxv_cnt[0];
`ifdef SPI_SLAVE_FRAME_ERR_EN
      begin
         int fc;
         fc = ferr_cnt[0];
         xfer(0, 7, 32'h0000_00FF, 1'b1, 1'b1, cap);
         chk("trunc_frame_err", ferr_cnt[0] - fc, 32'd2);
      end
`else
      xfer(0, 7, 32'h0000_00FF, 1'b1, 1'b1, cap);
`endif
      chk("trunc_no_rx_valid", rxv_cnt[0] - rc0, 32'd0);
      chk("trunc_rx_hold", {16'h0, rx_data[0]}, {16'h0, prev_rx});
      xfer(0, 16, 32'h0000_BEEF, 1'b1, 1'b1, cap);
      chk("after_trunc_rx", {16'h0, rx_data[0]}, 32'hBEEF);
      chk("after_trunc_pulse", rxv_cnt[0] - rc0, 32'd1);

      // Reset mid-word at bit 9 with cs_n held low
      preload(0, 16'h3C3C);
      xfer(0, 9, 32'h0000_F00F, 1'b1, 1'b0, cap);
      chk("mid_active", {31'd0, active[0]}, 32'd1);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      chk("rst_mid_miso", {31'd0, miso[0]}, 32'd0);
      chk("rst_mid_miso_oe", {31'd0, miso_oe[0]}, 32'd0);
      chk("rst_mid_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
      chk("rst_mid_rx_data", {16'h0, rx_data[0]}, 32'h0);
      chk("rst_mid_active", {31'd0, active[0]}, 32'd0);
      rc0 = rxv_cnt[0];
      xfer(0, 16, 32'h0000_AAAA, 1'b0, 1'b0, cap);
      wait_clk(H);
      chk("rst_hold_idle_active", {31'd0, active[0]}, 32'd0);
      chk("rst_hold_no_rx_valid", rxv_cnt[0] - rc0, 32'd0);
      cs_n[0] = 1'b1;
      wait_clk(H);
      xfer(0, 16, 32'h0000_C0DE, 1'b1, 1'b1, cap);
      chk("post_rst_rx", {16'h0, rx_data[0]}, 32'hC0DE);
      chk("post_rst_pulse", rxv_cnt[0] - rc0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
